sub_bytes_seq: RTL and testbench

Byte-serial AES SubBytes / InvSubBytes engine for the AES-OFB-GMAC IP. It accepts a 128-bit state over a valid/ready handshake and pushes it through a small number of shared Canright S-box instances (`bSbox`), with direction selected per transaction. It returns the substituted state over a second valid/ready handshake. It sits between the round datapath (and the key-schedule sequencer) and the S-box, so that area stays at LANES S-boxes instead of 16.

---
 rtl/sub_bytes_seq.sv | 202 ++++++++++++++++++++
 tb/tb_sub_bytes_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// Byte-serial AES SubBytes / InvSubBytes engine.
// A 128-bit state is accepted over a valid/ready handshake. It is substituted
// LANES bytes per cycle through shared S-box instances, with an optional
// register stage after the S-boxes. The result is returned over a second
// valid/ready handshake.

// Forward/inverse AES S-box with Canright's bSbox port semantics. It is built
// as an affine map around a GF(2^8) inversion, so encrypt=1 gives S(a) and
// encrypt=0 gives InvS(a).
module bSbox (
  input  logic [7:0] a_i,
  input  logic       encrypt_i,
  output logic [7:0] q_o
);

  // Multiply two elements of GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // The inverse is x^254, formed as the product of x^2, x^4, ..., x^128.
  // An input of 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  logic [7:0] pre;
  logic [7:0] inv;

  // The inverse direction undoes the affine map before inversion.
  // The forward direction applies the map after inversion.
  assign pre = encrypt_i ? a_i : (rotl(a_i, 1) ^ rotl(a_i, 3) ^ rotl(a_i, 6) ^ 8'h05);
  assign inv = gf_inv(pre);
  assign q_o = encrypt_i ? (inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63)
                         : inv;

endmodule

module sub_bytes_seq #(
  parameter int LANES = 1,
  parameter int PIPE  = 0
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic         IN_ENCRYPT,
  input  logic [127:0] STATE_IN,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] STATE_OUT,
  output logic         BUSY
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = $clog2(GROUPS);
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            enc_q, enc_d;
  logic [127:0]    work_q, work_d;

  logic [7:0]      sbox_in  [LANES];
  logic [7:0]      sbox_out [LANES];
  logic [7:0]      wb_data  [LANES];
  logic            wb_en;
  logic [CW-1:0]   wb_cnt;

  // Lane j reads byte LANES*cnt+j of the work register.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [3:0] rd_idx;
    assign rd_idx     = 4'(LANES * int'(cnt_q) + j);
    assign sbox_in[j] = work_q[{rd_idx, 3'b000} +: 8];
    bSbox u_sbox (
      .a_i       (sbox_in[j]),
      .encrypt_i (enc_q),
      .q_o       (sbox_out[j])
    );
  end

  if (PIPE != 0) begin : g_pipe
    logic          pv_q;
    logic [CW-1:0] pcnt_q;
    logic [7:0]    pres_q [LANES];

    // S-box output stage, written back one cycle later at the registered group.
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        pv_q   <= 1'b0;
        pcnt_q <= '0;
        for (int j = 0; j < LANES; j++) pres_q[j] <= 8'h00;
      end else begin
        pv_q   <= (state_q == ST_RUN);
        pcnt_q <= cnt_q;
        for (int j = 0; j < LANES; j++) pres_q[j] <= sbox_out[j];
      end
    end

    assign wb_en  = pv_q;
    assign wb_cnt = pcnt_q;
    for (genvar j = 0; j < LANES; j++) begin : g_wb
      assign wb_data[j] = pres_q[j];
    end
  end else begin : g_comb
    assign wb_en  = (state_q == ST_RUN);
    assign wb_cnt = cnt_q;
    for (genvar j = 0; j < LANES; j++) begin : g_wb
      assign wb_data[j] = sbox_out[j];
    end
  end

  // Next-state logic for the FSM, group counter and direction latch.
  always_comb begin
    // NOTE: every target gets a default first, so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    enc_d   = enc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          enc_d   = IN_ENCRYPT;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = (PIPE != 0) ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  if (OUT_READY) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Work register: load on accept, otherwise write back each substituted group in place.
  always_comb begin
    logic [3:0] wr_idx;
    wr_idx = 4'h0;
    work_d = work_q;
    if (state_q == ST_IDLE && IN_VALID) begin
      work_d = STATE_IN;
    end else if (wb_en) begin
      for (int j = 0; j < LANES; j++) begin
        wr_idx = 4'(LANES * int'(wb_cnt) + j);
        work_d[{wr_idx, 3'b000} +: 8] = wb_data[j];
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      enc_q   <= 1'b1;
      // NOTE: the work register is reset on purpose so that STATE_OUT reads zero after reset.
      work_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      work_q  <= work_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign BUSY      = (state_q != ST_IDLE);
  assign STATE_OUT = work_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq. It instantiates three configurations,
// (LANES,PIPE) = (1,0), (4,1) and (2,1), and compares each result against
// hand-computed constants and a log/antilog S-box model.
module tb_sub_bytes_seq;

  logic         CLK;
  logic         RESETN;
  logic         iv   [3];
  logic         ir   [3];
  logic         enc  [3];
  logic [127:0] sin  [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] sout [3];
  logic         busy [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sbox_m  [256];
  logic [7:0] isbox_m [256];
  int         lat_tab [3] = '{16, 5, 9};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  sub_bytes_seq #(.LANES(1), .PIPE(0)) dut0 (
    .CLK(CLK), .RESETN(RESETN), .IN_VALID(iv[0]), .IN_READY(ir[0]), .IN_ENCRYPT(enc[0]),
    .STATE_IN(sin[0]), .OUT_VALID(ov[0]), .OUT_READY(ordy[0]), .STATE_OUT(sout[0]), .BUSY(busy[0]));
  sub_bytes_seq #(.LANES(4), .PIPE(1)) dut1 (
    .CLK(CLK), .RESETN(RESETN), .IN_VALID(iv[1]), .IN_READY(ir[1]), .IN_ENCRYPT(enc[1]),
    .STATE_IN(sin[1]), .OUT_VALID(ov[1]), .OUT_READY(ordy[1]), .STATE_OUT(sout[1]), .BUSY(busy[1]));
  sub_bytes_seq #(.LANES(2), .PIPE(1)) dut2 (
    .CLK(CLK), .RESETN(RESETN), .IN_VALID(iv[2]), .IN_READY(ir[2]), .IN_ENCRYPT(enc[2]),
    .STATE_IN(sin[2]), .OUT_VALID(ov[2]), .OUT_READY(ordy[2]), .STATE_OUT(sout[2]), .BUSY(busy[2]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Builds the tables from powers of the generator 3 (log/antilog inversion).
  task automatic build_model();
    logic [7:0] ex [255];
    int         lg [256];
    logic [7:0] e;
    logic [7:0] inv;
    logic [7:0] s;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = e;
      lg[e] = i;
      e = e ^ xt(e);
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      sbox_m[a] = s;
      isbox_m[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st, input logic e);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = st[8*i +: 8];
      r[8*i +: 8] = e ? sbox_m[b] : isbox_m[b];
    end
    return r;
  endfunction

  // One transaction on DUT d. With hammer set, IN_VALID stays high and
  // IN_ENCRYPT/STATE_IN change every cycle after the accept. hold = number of
  // extra DONE cycles with OUT_READY low.
  task automatic txn(input int d, input logic e, input logic [127:0] st, input logic [127:0] expv,
                     input int exp_lat, input bit hammer, input int hold, input string tag);
    int k;
    int lat;
    enc[d]  = e;
    sin[d]  = st;
    iv[d]   = 1'b1;
    ordy[d] = 1'b0;
    k = 0;
    while (ir[d] !== 1'b1 && k < 100) begin
      @(posedge CLK); #1;
      k++;
    end
    check({tag, ":accept_wait"}, 128'(k), 128'd0);
    @(posedge CLK); #1;
    if (!hammer) iv[d] = 1'b0;
    check({tag, ":busy"}, 128'(busy[d]), 128'd1);
    check({tag, ":in_ready_run"}, 128'(ir[d]), 128'd0);
    lat = 0;
    while (ov[d] !== 1'b1 && lat < 100) begin
      if (hammer) begin
        enc[d] = ~enc[d];
        sin[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge CLK); #1;
      lat++;
    end
    check({tag, ":latency"}, 128'(lat), 128'(exp_lat));
    check({tag, ":data"}, sout[d], expv);
    for (int h = 0; h < hold; h++) begin
      if (hammer) begin
        enc[d] = ~enc[d];
        sin[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge CLK); #1;
      check({tag, ":hold_data"}, sout[d], expv);
      check({tag, ":hold_in_ready"}, 128'(ir[d]), 128'd0);
    end
    ordy[d] = 1'b1;
    @(posedge CLK); #1;
    ordy[d] = 1'b0;
    check({tag, ":out_valid_drop"}, 128'(ov[d]), 128'd0);
    check({tag, ":in_ready_idle"}, 128'(ir[d]), 128'd1);
  endtask

  initial begin
    logic [127:0] st;
    logic         e;

    RESETN = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; enc[d] = 1'b0; sin[d] = '0; ordy[d] = 1'b0;
    end
    build_model();

    // Reset values.
    #2 RESETN = 1'b0;
    #1;
    check("rst:in_ready",  128'(ir[0]),   128'd1);
    check("rst:out_valid", 128'(ov[0]),   128'd0);
    check("rst:busy",      128'(busy[0]), 128'd0);
    check("rst:state_out", sout[0],       128'd0);
    check("rst:state_out_l4", sout[1],    128'd0);
    check("rst:in_ready_l2",  128'(ir[2]), 128'd1);
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK); #1;

    // SubBytes sweep and InvSubBytes round trip.
    txn(0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76,
        16, 1'b0, 0, "sub_sweep");
    txn(0, 1'b0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f,
        16, 1'b0, 0, "inv_roundtrip");
    txn(0, 1'b0, 128'h6316ed7c7c7c7c7c7c7c7c7c7c7c7c7c, 128'h00ff5301010101010101010101010101,
        16, 1'b0, 0, "inv_spot");

    // Direction latch with IN_ENCRYPT toggling, then 20 cycles of back-pressure.
    txn(0, 1'b1, {128{1'b1}}, {16{8'h16}}, 16, 1'b1, 20, "dir_latch_bp");
    // IN_VALID is still high: the next accept must follow immediately.
    txn(0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76,
        16, 1'b0, 0, "after_bp");

    // Other configurations on the sweep vector.
    txn(1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76,
        5, 1'b0, 0, "sweep_l4p1");
    txn(2, 1'b0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f,
        9, 1'b0, 0, "inv_l2p1");

    // Random matrix against the model, both directions.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 400; n++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        e  = 1'($urandom_range(0, 1));
        txn(d, e, st, model(st, e), lat_tab[d], 1'b0, 0, "matrix");
      end
    end

    // Reset asserted at RUN cycle 7.
    enc[0] = 1'b1;
    sin[0] = 128'h0123456789abcdeffedcba9876543210;
    iv[0]  = 1'b1;
    @(posedge CLK); #1;
    iv[0] = 1'b0;
    repeat (7) @(posedge CLK);
    #1 RESETN = 1'b0;
    #1;
    check("midrst:out_valid", 128'(ov[0]),   128'd0);
    check("midrst:in_ready",  128'(ir[0]),   128'd1);
    check("midrst:state_out", sout[0],       128'd0);
    check("midrst:busy",      128'(busy[0]), 128'd0);
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    @(posedge CLK); #1;
    st = 128'h0123456789abcdeffedcba9876543210;
    txn(0, 1'b1, st, model(st, 1'b1), 16, 1'b0, 0, "after_midrst");
    txn(0, 1'b0, model(st, 1'b1), st, 16, 1'b0, 0, "after_midrst_inv");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
